// File: rtl/riscv_mem_pkg.sv
// Shared funct3 encodings, LSU state type and access-decode helpers for the MEM-stage LSU.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } lsu_state_t;

    // Loads accept LB/LH/LW/LBU/LHU, stores accept SB/SH/SW; read and write together is illegal.
    function automatic logic op_is_legal(input logic rd, input logic wr, input logic [2:0] f3);
        logic legal;
        legal = 1'b0;
        if (rd && wr) begin
            legal = 1'b0;
        end else if (wr) begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else if (rd) begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        end
        return legal;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lsb);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = lsb[0];
            F3_W:        mis = (lsb != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Halves use only addr[1], so a misaligned half lands on its naturally aligned lane.
    function automatic logic [3:0] byte_enable(input logic wr, input logic [2:0] f3,
                                               input logic [1:0] lsb);
        logic [3:0] be;
        if (!wr) begin
            be = 4'hF;
        end else begin
            case (f3)
                F3_B:    be = 4'b0001 << lsb;
                F3_H:    be = 4'b0011 << {lsb[1], 1'b0};
                default: be = 4'hF;
            endcase
        end
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] lanes;
        case (f3)
            F3_B:    lanes = {4{data[7:0]}};
            F3_H:    lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack bus between the MEM-stage LSU (master) and the data memory (slave).
interface mem_stage_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a load word and sign- or zero-extends it to 32 bits.
module load_extend
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    data_o = rdata_i;
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            default: data_o = '0;
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs EX/MEM loads/stores over a req/ack bus and stalls until done.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of issuing them truncated.
module mem_stage_lsu
    import riscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [31:0]     addr_i,
    input  logic [31:0]     store_data_i,
    input  logic [2:0]      funct3_i,
    output logic            stall_o,
    output logic [31:0]     load_data_o,
    output logic            done_o,
    output logic            err_o,
    output logic            misalign_o,
    mem_stage_lsu_if.master dmem
);
    localparam logic [3:0] TimeoutCnt = 4'(TIMEOUT_CYCLES);

    lsu_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        err_q, err_d;
    logic        misalign_q, misalign_d;

    logic        op;
    logic        legal;
    logic        trap;
    logic        busy;
    logic [3:0]  cnt_inc;
    logic [31:0] ext_data;

    assign op      = mem_read_i | mem_write_i;
    assign legal   = op_is_legal(mem_read_i, mem_write_i, funct3_i);
    assign cnt_inc = cnt_q + 4'd1;

`ifdef MISALIGN_TRAP_EN
    assign trap = is_misaligned(funct3_i, addr_i[1:0]);
`else
    // Without trapping, misalign_q never sets and misalign_o folds to a constant 0.
    assign trap = 1'b0;
`endif

    load_extend u_load_extend (
        .rdata_i  (dmem.rdata),
        .addr_i   (addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        err_d       = err_q;
        misalign_d  = misalign_q;
        stall_o     = 1'b0;

        unique case (state_q)
            StIdle: begin
                stall_o = op;
                if (op) begin
                    load_data_d = '0;
                    err_d       = 1'b0;
                    misalign_d  = 1'b0;
                    if (!legal) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (trap) begin
                        misalign_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        addr_d   = addr_i;
                        funct3_d = funct3_i;
                        we_d     = mem_write_i;
                        be_d     = byte_enable(mem_write_i, funct3_i, addr_i[1:0]);
                        wdata_d  = store_lanes(funct3_i, store_data_i);
                        cnt_d    = '0;
                        state_d  = StBusy;
                    end
                end
            end
            StBusy: begin
                stall_o = 1'b1;
                // An ack arriving on the expiry cycle still completes the access normally.
                if (dmem.ack) begin
                    load_data_d = we_q ? '0 : ext_data;
                    state_d     = StDone;
                end else if (cnt_inc == TimeoutCnt) begin
                    load_data_d = '0;
                    err_d       = 1'b1;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            err_q       <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
            misalign_q  <= misalign_d;
        end
    end

    assign busy   = (state_q == StBusy);
    assign done_o = (state_q == StDone);

    assign load_data_o = done_o ? load_data_q : '0;
    assign err_o       = done_o & err_q;
    assign misalign_o  = done_o & misalign_q;

    // Bus fields are zeroed outside BUSY so the memory never sees stale request data.
    assign dmem.req   = busy;
    assign dmem.we    = busy & we_q;
    assign dmem.addr  = busy ? {addr_q[31:2], 2'b00} : '0;
    assign dmem.be    = busy ? be_q : '0;
    assign dmem.wdata = busy ? wdata_q : '0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized self-checking bench for mem_stage_lsu against a transaction-level reference model.
module tb_mem_stage_lsu;
    import riscv_mem_pkg::*;

    localparam int unsigned TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic [2:0]  funct3_i;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        done_o;
    logic        err_o;
    logic        misalign_o;

    mem_stage_lsu_if dmem_bus ();

    mem_stage_lsu #(
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .funct3_i     (funct3_i),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .misalign_o   (misalign_o),
        .dmem         (dmem_bus.master)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [2:0] load_f3 [5];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] f3);
        if (rd && wr) return 1'b0;
        if (wr) return (f3 <= 3'd2);
        if (rd) return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return 1'b0;
    endfunction

    // Access size in bytes from funct3; only meaningful for legal funct3 values.
    function automatic int unsigned model_size(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic int unsigned model_lane(input logic [31:0] addr, input int unsigned size);
        return (addr & ~(size - 32'd1)) % 32'd4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [2:0] f3);
        int unsigned size;
        int unsigned lane;
        logic [31:0] raw;
        size = model_size(f3);
        lane = model_lane(addr, size);
        raw  = rdata >> (8 * lane);
        if (size < 4) begin
            raw = raw & ((32'd1 << (8 * size)) - 32'd1);
            // Signed loads: values with the top bit set wrap to their negative 32-bit form.
            if (f3 < 3'd4 && raw >= (32'd1 << (8 * size - 1)))
                raw = raw - (32'd1 << (8 * size));
        end
        return raw;
    endfunction

    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdata, input int unsigned delay);
        bit          legal;
        bit          mis;
        bit          to;
        int unsigned size;
        int unsigned lane;
        int          busy_n;
        logic [31:0] exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_ld;
        logic [31:0] rep;

        legal = model_legal(rd, wr, f3);
        size  = model_size(f3);
        lane  = model_lane(addr, size);
        mis   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = legal && ((addr % size) != 0);
`endif
        exp_be = wr ? (((32'd1 << size) - 32'd1) << lane) : 32'hF;
        rep    = (size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'd1;
        exp_wd = (size == 4) ? data : (data & ((32'd1 << (8 * size)) - 32'd1)) * rep;
        to     = (delay >= TIMEOUT);
        busy_n = to ? int'(TIMEOUT) : int'(delay) + 1;

        @(negedge clk);
        mem_read_i    = rd;
        mem_write_i   = wr;
        funct3_i      = f3;
        addr_i        = addr;
        store_data_i  = data;
        dmem_bus.ack  = 1'($urandom_range(0, 1));
        dmem_bus.rdata = $urandom;
        #1;
        check_eq("idle_stall", 32'(stall_o), 32'(rd | wr));
        check_eq("idle_req", 32'(dmem_bus.req), 32'd0);
        check_eq("idle_done", 32'(done_o), 32'd0);

        if (legal && !mis) begin
            for (int k = 0; k < busy_n; k++) begin
                @(negedge clk);
                dmem_bus.ack   = (k == int'(delay));
                dmem_bus.rdata = (k == int'(delay)) ? rdata : $urandom;
                #1;
                check_eq("busy_req", 32'(dmem_bus.req), 32'd1);
                check_eq("busy_stall", 32'(stall_o), 32'd1);
                check_eq("busy_done", 32'(done_o), 32'd0);
                check_eq("busy_we", 32'(dmem_bus.we), 32'(wr));
                check_eq("busy_addr", dmem_bus.addr, addr & 32'hFFFF_FFFC);
                check_eq("busy_be", 32'(dmem_bus.be), exp_be);
                if (wr) check_eq("busy_wdata", dmem_bus.wdata, exp_wd);
            end
        end

        exp_ld = (!legal || mis || to || wr) ? 32'd0 : model_load(rdata, addr, f3);
        @(negedge clk);
        dmem_bus.ack   = 1'($urandom_range(0, 1));
        dmem_bus.rdata = $urandom;
        #1;
        check_eq("done_pulse", 32'(done_o), 32'd1);
        check_eq("done_stall", 32'(stall_o), 32'd0);
        check_eq("done_req", 32'(dmem_bus.req), 32'd0);
        check_eq("done_err", 32'(err_o), 32'(!legal || (!mis && to)));
        check_eq("done_misalign", 32'(misalign_o), 32'(mis));
        if (!(legal && !mis && wr)) check_eq("done_load", load_data_o, exp_ld);

        @(negedge clk);
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b0;
        dmem_bus.ack = 1'($urandom_range(0, 1));
        #1;
        check_eq("after_done", 32'(done_o), 32'd0);
        check_eq("after_stall", 32'(stall_o), 32'd0);
        check_eq("after_req", 32'(dmem_bus.req), 32'd0);
    endtask

    initial begin
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        int unsigned kind;
        int unsigned dly;

        load_f3[0] = F3_B;
        load_f3[1] = F3_H;
        load_f3[2] = F3_W;
        load_f3[3] = F3_BU;
        load_f3[4] = F3_HU;

        rst            = 1'b1;
        mem_read_i     = 1'b0;
        mem_write_i    = 1'b0;
        addr_i         = '0;
        store_data_i   = '0;
        funct3_i       = '0;
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = '0;

        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_stall", 32'(stall_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_err", 32'(err_o), 32'd0);
        check_eq("rst_misalign", 32'(misalign_o), 32'd0);
        check_eq("rst_load", load_data_o, 32'd0);
        check_eq("rst_req", 32'(dmem_bus.req), 32'd0);
        mem_read_i = 1'b1;
        #1;
        check_eq("rst_stall_op", 32'(stall_o), 32'd1);
        mem_read_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        run_txn(1'b1, 1'b0, F3_B,  32'h0000_0103, 32'h0, 32'h80FF_0000, 2);
        run_txn(1'b0, 1'b1, F3_H,  32'h0000_0202, 32'h1234_ABCD, 32'h0, 1);
        run_txn(1'b1, 1'b0, F3_W,  32'h0000_0300, 32'h0, 32'h0, 20);
        run_txn(1'b1, 1'b1, F3_W,  32'h0000_0010, 32'h0, 32'h0, 0);
        run_txn(1'b1, 1'b0, F3_W,  32'h0000_0101, 32'h0, 32'hCAFE_F00D, 0);
        run_txn(1'b1, 1'b0, F3_HU, 32'h0000_0042, 32'h0, 32'h8765_4321, 14);
        run_txn(1'b1, 1'b0, F3_H,  32'h0000_0040, 32'h0, 32'h0000_8001, 15);
        run_txn(1'b0, 1'b1, F3_BU, 32'h0000_0040, 32'h55, 32'h0, 0);
        run_txn(1'b1, 1'b0, 3'b011, 32'h0000_0040, 32'h0, 32'h0, 0);
        run_txn(1'b0, 1'b1, F3_B,  32'h0000_0051, 32'h0000_00A5, 32'h0, 0);

        // Reset while BUSY: request must drop and no done pulse may follow the late ack.
        @(negedge clk);
        mem_read_i   = 1'b1;
        funct3_i     = F3_W;
        addr_i       = 32'h0000_0040;
        dmem_bus.ack = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rstbusy_req_before", 32'(dmem_bus.req), 32'd1);
        rst        = 1'b1;
        mem_read_i = 1'b0;
        @(negedge clk);
        rst          = 1'b0;
        dmem_bus.ack = 1'b1;
        #1;
        check_eq("rstbusy_req", 32'(dmem_bus.req), 32'd0);
        check_eq("rstbusy_done", 32'(done_o), 32'd0);
        check_eq("rstbusy_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        dmem_bus.ack = 1'b0;
        #1;
        check_eq("rstbusy_req2", 32'(dmem_bus.req), 32'd0);
        check_eq("rstbusy_done2", 32'(done_o), 32'd0);
        check_eq("rstbusy_err2", 32'(err_o), 32'd0);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 19);
            rd   = (kind <= 10);
            wr   = (kind == 0) || (kind > 10);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (wr)                   f3 = 3'($urandom_range(0, 2));
            else                           f3 = load_f3[$urandom_range(0, 4)];
            dly = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 18) : $urandom_range(0, 3);
            run_txn(rd, wr, f3, $urandom, $urandom, $urandom, dly);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
